// File: rtl/popcount_pattern_gen.sv
// Sequential inverse of a 4-input one-hot popcount: given a one-hot weight, emits every
// 4-bit pattern with that many ones, ascending, one per ready/valid handshake.
module popcount_pattern_gen (
    input  logic clk,
    input  logic reset,
    input  logic ena,
    input  logic start,
    input  logic v,
    input  logic w,
    input  logic x,
    input  logic y,
    input  logic z,
    input  logic ready,
    output logic a,
    output logic b,
    output logic c,
    output logic d,
    output logic valid,
    output logic last,
    output logic busy,
    output logic done,
    output logic err
);

    typedef enum logic [1:0] {StIdle, StScan, StHold} state_e;

    state_e      state;
    logic [3:0]  cand;
    logic [2:0]  k;

    logic [2:0]  code_ones;
    logic        code_ok;
    logic [2:0]  code_k;
    logic [2:0]  cand_ones;
    logic [3:0]  max_pat;

    always_comb begin
        code_ones = {2'b00, v} + {2'b00, w} + {2'b00, x} + {2'b00, y} + {2'b00, z};
        code_ok   = (code_ones == 3'd1);
        code_k    = 3'd0;
        if (w)      code_k = 3'd1;
        else if (x) code_k = 3'd2;
        else if (y) code_k = 3'd3;
        else if (z) code_k = 3'd4;
        cand_ones = {2'b00, cand[0]} + {2'b00, cand[1]} + {2'b00, cand[2]} + {2'b00, cand[3]};
        // Largest pattern of weight k is k ones packed at the MSB end.
        max_pat   = ~(4'hF >> k);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= StIdle;
            cand           <= 4'd0;
            k              <= 3'd0;
            {a, b, c, d}   <= 4'd0;
            valid          <= 1'b0;
            last           <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            err            <= 1'b0;
        end else if (ena) begin
            done <= 1'b0;
            err  <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (start) begin
                        if (code_ok) begin
                            k     <= code_k;
                            cand  <= 4'd0;
                            busy  <= 1'b1;
                            state <= StScan;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                StScan: begin
                    if (cand_ones == k) begin
                        {a, b, c, d} <= cand;
                        valid        <= 1'b1;
                        last         <= (cand == max_pat);
                        state        <= StHold;
                    end else begin
                        cand <= cand + 4'd1;
                    end
                end
                StHold: begin
                    if (ready) begin
                        valid <= 1'b0;
                        if (last) begin
                            last  <= 1'b0;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= StIdle;
                        end else begin
                            cand  <= cand + 4'd1;
                            state <= StScan;
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/popcount_pattern_gen.md
# popcount_pattern_gen

- Sequential inverse of the 4-input one-hot population counter.
- Accepts a one-hot weight code (v = 0 ones, w = 1, x = 2, y = 3, z = 4).
- Enumerates, one per handshake, every 4-bit pattern {a,b,c,d} with exactly that many ones, in ascending numeric order (a = MSB).
- Drives the counter's input side in self-checking loops and exhaustive stimulus generation: each emitted pattern, fed to the counter, must reproduce the requested one-hot code.

## Interface

Parameters: none. Fixed 4-bit pattern width, 5-way one-hot weight.

- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- ena  input  1  clock enable; 0 freezes all state and outputs
- start  input  1  request a new enumeration; sampled only in IDLE with ena=1
- v, w, x, y, z  input  1 each  one-hot requested weight 0..4; sampled with start
- ready  input  1  downstream accepts the current pattern
- a, b, c, d  output  1 each  current pattern, a = MSB
- valid  output  1  pattern on a..d is valid
- last  output  1  current pattern is the final one of the enumeration; qualified by valid
- busy  output  1  enumeration in progress (state ≠ IDLE)
- done  output  1  one-cycle pulse after the final pattern is accepted
- err  output  1  one-cycle pulse: start seen with a weight code not exactly one-hot

## Operation

- All outputs are registered.
- Internal state: 2-bit FSM, 4-bit candidate counter `cand`, 3-bit latched weight `k`.
- **IDLE**
  - On start=1:
    - If exactly one of v..z is set: latch k, set cand=0, go to SCAN.
    - Otherwise: pulse err, stay in IDLE.
- **SCAN**
  - Each enabled cycle, compare popcount(cand) with k.
  - On a match:
    - load a..d ← cand and set valid=1.
    - set last=1 if cand equals the maximal pattern for k (k0: 0000, k1: 1000, k2: 1100, k3: 1110, k4: 1111).
    - go to HOLD.
  - No match: cand ← cand+1.
  - A match always occurs by cand=15, so cand never wraps in SCAN.
- **HOLD**
  - a..d, valid and last are held stable until ready=1.
  - On ready with last=1: valid←0, last←0, pulse done, go to IDLE.
  - On ready with last=0: valid←0, cand←cand+1, go to SCAN.
- Patterns per weight: k0 = 1, k1 = 4, k2 = 6, k3 = 4, k4 = 1.
- In IDLE, start is ignored while busy. start and ready arriving together in IDLE: only start acts.
- ena=0: every register holds, including pulse outputs, which stay asserted until the next enabled cycle.
- reset=1 (takes priority over ena):
  - state IDLE; cand, k, a..d, valid, last, busy, done and err all 0.
  - Mid-enumeration reset aborts without a done pulse.

## Timing

- Edges are counted with ena=1. start is sampled at edge E0, which enters SCAN with cand=0.
- cand=n is evaluated at edge E(n+1).
- First valid appears after edge E(p+1), where p = numeric value of the first pattern.
  - Weight 0: after E1.
  - Weight 4: after E16.
- A HOLD→SCAN transition costs at least one cycle with valid=0. Each additional skipped candidate adds one more valid=0 cycle.
- ready is sampled only while valid=1. A ready pulse while valid=0 is ignored.
- busy goes 1 at E0 and goes 0 at the edge that accepts the last pattern. done is 1 in the following cycle.
- err is 1 for the cycle after the bad start edge. busy stays 0.

## Test plan

- **Reset and idle:** reset high for 2 cycles mid-enumeration (weight 2, after 2 accepts) → all outputs 0, busy=0, no done pulse. A following start works normally.
- **Weight 2, ready tied high:** → exactly six valids, in order 0011, 0101, 0110, 1001, 1010, 1100. last is only on 1100. done one cycle after. Each pattern fed to the popcount counter yields x=1.
- **Weight 0 and weight 4:** → single pattern each, 0000 and 1111 respectively, with last=1.
  - Weight 0: first valid after E1.
  - Weight 4: first valid after E16.
- **Backpressure, weight 1:** ready held low 5 cycles on the first pattern 0001 → a..d, valid and last stable throughout. Then 0010, 0100, 1000 follow; last only on 1000.
- **Bad codes:** start with v..z = 00000, and separately 01100 → err pulses 1 cycle each, busy stays 0, no valid.
- **Stall and ignored start, weight 3:** ena low 3 cycles between patterns → no state or output change while low. A start raised while busy is ignored. The sequence 0111, 1011, 1101, 1110 is unchanged.
